// File: rtl/ksa_adder_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ksa_arb_pkg : shared constants, id-width helper and result-entry type      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ksa_arb_pkg;

  localparam int C_DEF_W         = 32;
  localparam int C_DEF_NREQ      = 4;
  localparam int C_DEF_RSP_DEPTH = 4;
  localparam int C_DEF_IDW       = $clog2(C_DEF_NREQ);

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Result entry at the default configuration
  typedef struct packed {
    logic [C_DEF_W:0]       sum;
    logic [C_DEF_IDW-1:0]   id;
  } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/ksa_adder_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ksa_adder_arbiter_if : requester/response bus; KSA_ARB_CIN_EN adds req_cin |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ksa_adder_arbiter_if
  import ksa_arb_pkg::*;
#(
  parameter int NREQ = C_DEF_NREQ,
  parameter int W    = C_DEF_W
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
`ifdef KSA_ARB_CIN_EN
  logic [NREQ-1:0]   req_cin;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;

  modport master (
`ifdef KSA_ARB_CIN_EN
    output req_cin,
`endif
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
`ifdef KSA_ARB_CIN_EN
    input  req_cin,
`endif
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface
`default_nettype wire

// File: rtl/ksa_adder_arbiter_core_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ksa_core_pipe : 2-stage Kogge-Stone adder (operand reg, sum reg) + id/cin  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ksa_core_pipe
  import ksa_arb_pkg::*;
#(
  parameter int W   = C_DEF_W,
  parameter int IDW = C_DEF_IDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic [W-1:0]   i_x,
  input  logic [W-1:0]   i_y,
  input  logic           i_cin,
  input  logic [IDW-1:0] i_id,
  output logic           o_valid,
  output logic [W:0]     o_sum,
  output logic [IDW-1:0] o_id
);
  localparam int LV = (W > 1) ? $clog2(W) : 1;

  logic           r_v1, r_cin, r_v2;
  logic [W-1:0]   r_x, r_y;
  logic [IDW-1:0] r_id1, r_id2;
  logic [W:0]     r_sum;

  logic [W-1:0]   w_g, w_p, w_gn, w_pn, w_p0;
  logic [W:0]     w_c, w_sum;

  // Payload registers only load with a valid op; valids always follow input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_cin <= 1'b0;
      r_id1 <= '0;
      r_v2  <= 1'b0;
      r_sum <= '0;
      r_id2 <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_x   <= i_x;
        r_y   <= i_y;
        r_cin <= i_cin;
        r_id1 <= i_id;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum <= w_sum;
        r_id2 <= r_id1;
      end
    end
  end

  always_comb begin
    w_g  = r_x & r_y;
    w_p  = r_x ^ r_y;
    w_p0 = w_p;
    w_gn = '0;
    w_pn = '0;
    for (int l = 0; l < LV; l++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = (1 << l); i < W; i++) begin
        w_gn[i] = w_g[i] | (w_p[i] & w_g[i-(1<<l)]);
        w_pn[i] = w_p[i] & w_p[i-(1<<l)];
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    // Full-span prefix terms fold the carry-in into every bit position
    w_c   = {w_g | (w_p & {W{r_cin}}), r_cin};
    w_sum = {w_c[W], w_p0 ^ w_c[W-1:0]};
  end

  assign o_valid = r_v2;
  assign o_sum   = r_sum;
  assign o_id    = r_id2;

endmodule
`default_nettype wire

// File: rtl/ksa_adder_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ksa_adder_arbiter : round-robin shared KSA adder with credit-guarded FIFO  |
// | Optional macro KSA_ARB_CIN_EN enables per-requester carry-in.  Rev 1.0     |
// +----------------------------------------------------------------------------+
module ksa_adder_arbiter
  import ksa_arb_pkg::*;
#(
  parameter int NREQ      = C_DEF_NREQ,
  parameter int W         = C_DEF_W,
  parameter int RSP_DEPTH = C_DEF_RSP_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  ksa_adder_arbiter_if.slave bus
);
  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = id_width(RSP_DEPTH);

  logic [IDW-1:0] r_last;
  logic [CW-1:0]  r_used, r_occ;
  logic [PW-1:0]  r_wr, r_rd;
  logic [W:0]     r_mem_sum [RSP_DEPTH];
  logic [IDW-1:0] r_mem_id  [RSP_DEPTH];

  logic           w_hi_any, w_lo_any, w_fire, w_pop, w_push, w_cin, w_rsp_valid;
  logic [IDW-1:0] w_hi_idx, w_lo_idx, w_idx, w_core_id;
  logic [W-1:0]   w_x, w_y;
  logic [W:0]     w_core_sum;

  // Prefer the lowest valid index above the last grant, else wrap to lowest
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && !w_lo_any) begin
        w_lo_any = 1'b1;
        w_lo_idx = IDW'(i);
      end
      if (bus.req_valid[i] && !w_hi_any && (IDW'(i) > r_last)) begin
        w_hi_any = 1'b1;
        w_hi_idx = IDW'(i);
      end
    end
  end

  assign w_idx         = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_fire        = rst && w_lo_any && (r_used < CW'(RSP_DEPTH));
  assign bus.req_ready = w_fire ? (NREQ'(1) << w_idx) : '0;

  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == IDW'(i)) begin
        w_x = bus.req_x[i*W +: W];
        w_y = bus.req_y[i*W +: W];
`ifdef KSA_ARB_CIN_EN
        w_cin = bus.req_cin[i];
`endif
      end
    end
  end

  ksa_core_pipe #(
    .W   (W),
    .IDW (IDW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_fire),
    .i_x     (w_x),
    .i_y     (w_y),
    .i_cin   (w_cin),
    .i_id    (w_idx),
    .o_valid (w_push),
    .o_sum   (w_core_sum),
    .o_id    (w_core_id)
  );

  assign w_rsp_valid   = (r_occ != '0);
  assign w_pop         = w_rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_sum   = w_rsp_valid ? r_mem_sum[r_rd] : '0;
  assign bus.rsp_id    = w_rsp_valid ? r_mem_id[r_rd]  : '0;

  // r_used spans in-flight plus queued ops, so a push always finds room
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= IDW'(NREQ - 1);
      r_used <= '0;
      r_occ  <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
    end else begin
      if (w_fire) begin
        r_last <= w_idx;
      end
      r_used <= r_used + CW'(w_fire) - CW'(w_pop);
      r_occ  <= r_occ  + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wr <= (r_wr == PW'(RSP_DEPTH - 1)) ? '0 : r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= (r_rd == PW'(RSP_DEPTH - 1)) ? '0 : r_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_sum[r_wr] <= w_core_sum;
      r_mem_id[r_wr]  <= w_core_id;
    end
  end

endmodule
`default_nettype wire

// File: doc/ksa_adder_arbiter.md
KSA_ADDER_ARBITER -- requirements
Module: ksa_adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter W, default 32: operand width; the sum width is W+1.
REQ-003 Parameter RSP_DEPTH, default 4: result FIFO depth; legal minimum 3.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port req_valid, input, NREQ: per-requester operation valid.
REQ-007 Port req_ready, output, NREQ: per-requester accept, one-hot or zero.
REQ-008 Port req_x, input, NREQ*W: packed X operands; requester i occupies bits [i*W +: W].
REQ-009 Port req_y, input, NREQ*W: packed Y operands, packed the same way as req_x.
REQ-010 Port rsp_valid, output, 1: a result is available.
REQ-011 Port rsp_ready, input, 1: the consumer accepts the result.
REQ-012 Port rsp_sum, output, W+1: the sum, with the carry-out in the MSB.
REQ-013 Port rsp_id, output, clog2(NREQ): index of the requester that issued the operation.

Function
REQ-014 The block SHALL share one adder core among all requesters and issue at most one operation per cycle.
REQ-015 An operation SHALL transfer on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready SHALL be combinational from req_valid, the round-robin pointer and the credit count; requesters must not make valid depend on ready.
REQ-017 Arbitration SHALL be round-robin: priority starts at (last_grant+1) mod NREQ; last_grant updates only on a transfer.
REQ-018 The adder core SHALL have two pipeline stages: an operand register and a sum register, with id carried alongside.
REQ-019 Latency: a transfer at edge k SHALL make the result visible at the FIFO head after edge k+2, provided the FIFO was empty.
REQ-020 Results SHALL enter a RSP_DEPTH-entry FIFO and leave in issue order.
REQ-021 rsp_valid SHALL equal "FIFO not empty"; an entry pops on an edge with rsp_valid and rsp_ready both high.
REQ-022 Credits: the block SHALL grant only when (in-flight ops + FIFO occupancy) < RSP_DEPTH, so no result is ever dropped and the pipeline never stalls.
REQ-023 A push and a pop in the same cycle on a full FIFO SHALL both succeed, and occupancy SHALL stay unchanged.
REQ-024 A pop on the same edge as a grant SHALL free the credit in the following cycle, not combinationally.
REQ-025 The sum SHALL be X+Y computed mod 2^(W+1); for example, all-ones + 1 gives carry-out 1 and low bits 0.
REQ-026 With no requests, the pipeline registers SHALL hold their values, and their valid bits SHALL clear.

Reset
REQ-027 On rst low: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, last_grant=NREQ-1 (so requester 0 wins first), all pipeline valids cleared, FIFO emptied, credits restored.
REQ-028 Reset mid-operation SHALL discard all in-flight and queued results; no response for them SHALL appear after release.
REQ-029 The first grant after reset release SHALL be possible on the first rising edge with rst high.

Configuration
REQ-030 Macro KSA_ARB_CIN_EN defined: add input port req_cin (NREQ bits, 1 per requester), carried with the operands, giving sum X+Y+cin.
REQ-031 Macro KSA_ARB_CIN_EN undefined: no req_cin port, and carry-in is tied to 0.

Structure
REQ-032 Shared package ksa_arb_pkg SHALL hold: default W, NREQ and RSP_DEPTH constants; the id-width function; the result-entry struct typedef (sum, id).
REQ-033 One sub-module ksa_core_pipe: 2-stage registered W-bit Kogge-Stone prefix adder with sideband id, valid and cin.
REQ-034 The round-robin arbiter, credit counter and FIFO SHALL reside in ksa_adder_arbiter itself.

Verification
REQ-035 Single request: req 2 with X=0x00000005, Y=0x00000007 -> rsp_id=2, rsp_sum=0x00000000C, 2 cycles after the transfer.
REQ-036 Overflow: X=0xFFFFFFFF, Y=0x00000001 -> rsp_sum=0x100000000; with KSA_ARB_CIN_EN and cin=1, X=Y=0xFFFFFFFF -> 0x1FFFFFFFF.
REQ-037 Fairness: all 4 requesters valid continuously for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3, with results in the same order.
REQ-038 Backpressure: rsp_ready=0, all requesters valid -> exactly 4 grants then req_ready all 0; raise rsp_ready -> 4 results in order, and granting resumes.
REQ-039 Reset mid-stream: assert rst with 2 in flight and 2 queued -> rsp_valid=0 immediately; after release, no stale results appear and the first grant goes to requester 0.
REQ-040 Full FIFO with simultaneous push and pop: occupancy stays 4, and no data is lost or duplicated, checked against a scoreboard over 1000 random ops.
